// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED matrix scan controller.
//   scan_state_t : per-slot FSM state (BLANK = outputs off, DRIVE = column lit)
//   LED_OFF      : row drive value with every row dark (rows are active-low)
//   COL_OFF      : column select value with no column selected (active-low)
//   col_select() : active-low one-cold column select for a column index
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [7:0] LED_OFF = 8'hFF;
    localparam logic [3:0] COL_OFF = 4'hF;

    // Exactly one bit low, at the position of the selected column.
    function automatic logic [3:0] col_select(input logic [1:0] c);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << c;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// ---------------------------------------------------------------------------
// led_pwm
// 4-bit brightness PWM used while a column is being driven.
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   drive_next  : the controller is in DRIVE on the coming cycle
//   drive_start : the coming cycle is the first DRIVE cycle of a slot
//   bright      : brightness 0..15 of the frame on display
//   lit_en      : pixels set in the frame may be lit on the coming cycle
// lit_en is looked ahead by one cycle so the controller can register it
// straight into the row outputs and keep them aligned with the FSM state.
// ---------------------------------------------------------------------------
module led_pwm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       drive_next,
    input  logic       drive_start,
    input  logic [3:0] bright,
    output logic       lit_en
);

    logic [3:0] pwm_cnt;
    logic [3:0] pwm_next;

    // The PWM phase restarts at 0 on each entry to DRIVE and otherwise wraps
    // 15 -> 0 naturally through 4-bit overflow. Comparing with a strict
    // less-than keeps brightness 0 fully dark and brightness 15 dark for one
    // phase in sixteen.
    always_comb begin
        pwm_next = drive_start ? 4'd0 : pwm_cnt + 4'd1;
        lit_en   = drive_next && (pwm_next < bright);
    end

    // Counter parks at 0 outside DRIVE so every slot begins from a known phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 4'd0;
        end else if (drive_next) begin
            pwm_cnt <= pwm_next;
        end else begin
            pwm_cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// ---------------------------------------------------------------------------
// led_scan_ctrl
// Multiplexed 8-row x 4-column LED matrix driver with a double-buffered frame.
//   clk          : clock
//   rst_n        : asynchronous active-low reset
//   frame_data   : pixel map, bit 8*c+r is row r of column c, 1 = lit
//   frame_bright : frame brightness 0..15
//   frame_valid  : producer offers frame_data/frame_bright
//   frame_ready  : pending buffer is empty and can take a frame
//   frame_done   : one-cycle pulse after each full 4-column scan
//   led          : row drive, active-low
//   col          : column select, active-low, at most one bit low
// Each column owns a slot of SLOT_CYCLES clocks: BLANK_CYCLES of blanking
// (to let the column drivers turn off) followed by PWM-modulated drive.
// Outputs are registered from the next-state values, so led/col always
// match the FSM state of the current cycle.
// ---------------------------------------------------------------------------
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int SLOT_CYCLES  = 3000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] frame_data,
    input  logic [3:0]  frame_bright,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic        frame_done,
    output logic [7:0]  led,
    output logic [3:0]  col
);

    scan_state_t state;
    scan_state_t state_next;
    logic [15:0] slot_cnt;
    logic [15:0] slot_cnt_next;
    logic [1:0]  col_idx;
    logic [1:0]  col_idx_next;
    logic        slot_end;
    logic        frame_boundary;
    logic        accept;
    logic        drive_next;
    logic        drive_start;
    logic        lit_en;
    logic [7:0]  row_bits;

    logic [31:0] pend_data;
    logic [3:0]  pend_bright;
    logic [31:0] act_data;
    logic [3:0]  act_bright;

    // Next-state of the slot sequencer. The frame boundary is the final
    // cycle of the column-3 slot; the active buffer is swapped on that edge
    // while the coming cycle is blanking, so no half-old half-new column
    // is ever shown.
    always_comb begin
        slot_end       = (slot_cnt == 16'(SLOT_CYCLES - 1));
        frame_boundary = slot_end && (col_idx == 2'd3);
        slot_cnt_next  = slot_end ? 16'd0 : slot_cnt + 16'd1;
        col_idx_next   = slot_end ? col_idx + 2'd1 : col_idx;
        state_next     = (slot_cnt_next < 16'(BLANK_CYCLES)) ? BLANK : DRIVE;
        drive_next     = (state_next == DRIVE);
        drive_start    = drive_next && (state == BLANK);
        accept         = frame_valid && frame_ready;
        row_bits       = act_data[{col_idx_next, 3'b000} +: 8];
    end

    led_pwm u_pwm (
        .clk         (clk),
        .rst_n       (rst_n),
        .drive_next  (drive_next),
        .drive_start (drive_start),
        .bright      (act_bright),
        .lit_en      (lit_en)
    );

    // Scan FSM: slot counter, column index, state and the registered
    // row/column outputs all advance together from the next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BLANK;
            slot_cnt <= 16'd0;
            col_idx  <= 2'd0;
            led      <= LED_OFF;
            col      <= COL_OFF;
        end else begin
            state    <= state_next;
            slot_cnt <= slot_cnt_next;
            col_idx  <= col_idx_next;
            if (state_next == DRIVE) begin
                led <= ~(row_bits & {8{lit_en}});
                col <= col_select(col_idx_next);
            end else begin
                led <= LED_OFF;
                col <= COL_OFF;
            end
        end
    end

    // Frame handshake and double buffer. frame_ready doubles as the
    // "pending empty" flag. An accept can only happen while pending is
    // empty, so it never races with a promotion: a frame accepted on the
    // boundary cycle simply waits in pending for the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data   <= 32'd0;
            pend_bright <= 4'd0;
            act_data    <= 32'd0;
            act_bright  <= 4'd0;
            frame_ready <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= frame_boundary;
            if (frame_boundary && !frame_ready) begin
                act_data    <= pend_data;
                act_bright  <= pend_bright;
                frame_ready <= 1'b1;
            end
            if (accept) begin
                pend_data   <= frame_data;
                pend_bright <= frame_bright;
                frame_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_scan_ctrl
// Directed bench for led_scan_ctrl with SLOT_CYCLES=32, BLANK_CYCLES=4,
// so one column slot is 32 cycles and one full frame scan is 128 cycles.
// p counts cycles since the last reset release; the cycle with p%128==127
// is a frame boundary.
// ---------------------------------------------------------------------------
module tb_led_scan_ctrl;

    localparam int SLOT  = 32;
    localparam int BLANK = 4;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] frame_data;
    logic [3:0]  frame_bright;
    logic        frame_valid;
    logic        frame_ready;
    logic        frame_done;
    logic [7:0]  led;
    logic [3:0]  col;

    int total = 0;
    int bad   = 0;
    int p     = 0;

    // Reference model of what should be on screen and on the handshake.
    logic [31:0] m_act_data;
    logic [3:0]  m_act_bright;
    logic [31:0] m_pend_data;
    logic [3:0]  m_pend_bright;
    logic        m_ready;
    logic        m_done;
    logic [7:0]  exp_led;
    logic [3:0]  exp_col;

    led_scan_ctrl #(
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_data   (frame_data),
        .frame_bright (frame_bright),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_done   (frame_done),
        .led          (led),
        .col          (col)
    );

    always #5 clk = ~clk;

    // Model back to the post-reset picture: blank screen, empty pending.
    task automatic model_reset();
        p             = 0;
        m_act_data    = 32'd0;
        m_act_bright  = 4'd0;
        m_pend_data   = 32'd0;
        m_pend_bright = 4'd0;
        m_ready       = 1'b1;
        m_done        = 1'b0;
        exp_led       = 8'hFF;
        exp_col       = 4'hF;
    endtask

    // Advance one clock, update the model, and run the always-on monitor
    // (never two columns selected, rows dark whenever no column is selected).
    task automatic step();
        logic        bnd;
        logic        old_ready;
        logic        v;
        logic [31:0] d;
        logic [3:0]  b;
        logic [3:0]  one;
        int          s;
        int          c;
        int          pw;
        bnd       = (p % FRAME) == FRAME - 1;
        old_ready = m_ready;
        v         = frame_valid;
        d         = frame_data;
        b         = frame_bright;
        @(posedge clk);
        if (bnd && !old_ready) begin
            m_act_data   = m_pend_data;
            m_act_bright = m_pend_bright;
            m_ready      = 1'b1;
        end
        if (v && old_ready) begin
            m_pend_data   = d;
            m_pend_bright = b;
            m_ready       = 1'b0;
        end
        m_done = bnd;
        p++;
        #1;
        s = p % SLOT;
        c = (p / SLOT) % 4;
        if (s < BLANK) begin
            exp_led = 8'hFF;
            exp_col = 4'hF;
        end else begin
            pw      = (s - BLANK) % 16;
            one     = 4'b0001;
            exp_col = ~(one << c);
            for (int r = 0; r < 8; r++)
                exp_led[r] = ~(m_act_data[8*c+r] && (pw < int'(m_act_bright)));
        end
        total++;
        if ($countones(~col) > 1) begin
            bad++;
            $display("[TB] FAIL monitor_col_onecold p=%0d col=%b want at most one zero", p, col);
        end
        total++;
        if (col === 4'hF && led !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL monitor_blank_rows p=%0d led=%h want ff while col=f", p, led);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        frame_valid  = 1'b0;
        frame_data   = 32'd0;
        frame_bright = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (led !== 8'hFF || col !== 4'hF) begin
            bad++;
            $display("[TB] FAIL reset_outputs led=%h col=%b want ff/1111", led, col);
        end
        total++;
        if (frame_ready !== 1'b1 || frame_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_handshake ready=%b done=%b want 1/0", frame_ready, frame_done);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    // Column 0 fully set at brightness 15: dark for one PWM phase in 16.
    task automatic test_bright15();
        int lit;
        frame_valid  = 1'b1;
        frame_data   = 32'h0000_00FF;
        frame_bright = 4'd15;
        step();
        frame_valid = 1'b0;
        total++;
        if (frame_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b15_ready_low got=%b want 0", frame_ready);
        end
        lit = 0;
        while (p < 2 * FRAME) begin
            step();
            total++;
            if (led !== exp_led || col !== exp_col) begin
                bad++;
                $display("[TB] FAIL b15_scan p=%0d led=%h col=%b want %h/%b", p, led, col, exp_led, exp_col);
            end
            total++;
            if (frame_ready !== m_ready || frame_done !== m_done) begin
                bad++;
                $display("[TB] FAIL b15_handshake p=%0d ready=%b done=%b want %b/%b", p, frame_ready, frame_done, m_ready, m_done);
            end
            if (p >= 132 && p < 148 && led === 8'h00) lit++;
            if (p == 132) begin
                total++;
                if (led !== 8'h00 || col !== 4'b1110) begin
                    bad++;
                    $display("[TB] FAIL b15_col0_lit led=%h col=%b want 00/1110", led, col);
                end
            end
            if (p == 164 || p == 196 || p == 228) begin
                total++;
                if (led !== 8'hFF || col !== (p == 164 ? 4'b1101 : p == 196 ? 4'b1011 : 4'b0111)) begin
                    bad++;
                    $display("[TB] FAIL b15_other_cols p=%0d led=%h col=%b", p, led, col);
                end
            end
        end
        total++;
        if (lit != 15) begin
            bad++;
            $display("[TB] FAIL b15_lit_count got=%0d want 15", lit);
        end
    endtask

    // Every pixel set but brightness 0: rows stay dark, columns keep scanning.
    task automatic test_bright0();
        frame_valid  = 1'b1;
        frame_data   = 32'hFFFF_FFFF;
        frame_bright = 4'd0;
        step();
        frame_valid = 1'b0;
        while (p < 4 * FRAME) begin
            step();
            total++;
            if (led !== exp_led || col !== exp_col) begin
                bad++;
                $display("[TB] FAIL b0_scan p=%0d led=%h col=%b want %h/%b", p, led, col, exp_led, exp_col);
            end
            if (p >= 3 * FRAME) begin
                total++;
                if (led !== 8'hFF) begin
                    bad++;
                    $display("[TB] FAIL b0_dark p=%0d led=%h want ff", p, led);
                end
            end
            if (p == 388) begin
                total++;
                if (col !== 4'b1110) begin
                    bad++;
                    $display("[TB] FAIL b0_col_scan col=%b want 1110", col);
                end
            end
        end
    endtask

    // frame_valid held high: one accept per frame, done every 128 cycles.
    task automatic test_back_to_back();
        int accepts;
        int dones;
        accepts      = 0;
        dones        = 0;
        frame_valid  = 1'b1;
        frame_data   = 32'h0F0F_A5A5;
        frame_bright = 4'd9;
        while (p < 7 * FRAME) begin
            if (frame_ready === 1'b1) accepts++;
            step();
            if (frame_done === 1'b1) dones++;
            total++;
            if (frame_ready !== m_ready || frame_done !== m_done) begin
                bad++;
                $display("[TB] FAIL b2b_handshake p=%0d ready=%b done=%b want %b/%b", p, frame_ready, frame_done, m_ready, m_done);
            end
        end
        frame_valid = 1'b0;
        total++;
        if (accepts != 3 || dones != 3) begin
            bad++;
            $display("[TB] FAIL b2b_counts accepts=%0d dones=%0d want 3/3", accepts, dones);
        end
    endtask

    // Accept on the boundary cycle: shown only after the following boundary.
    task automatic test_boundary_accept();
        while (p < 8 * FRAME - 1) step();
        frame_valid  = 1'b1;
        frame_data   = 32'h0000_FF00;
        frame_bright = 4'd15;
        step();
        frame_valid = 1'b0;
        total++;
        if (frame_ready !== 1'b0 || frame_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bnd_accept ready=%b done=%b want 0/1", frame_ready, frame_done);
        end
        while (p < 1060) step();
        total++;
        if (led !== 8'h5A || col !== 4'b1101) begin
            bad++;
            $display("[TB] FAIL bnd_old_frame led=%h col=%b want 5a/1101", led, col);
        end
        while (p < 9 * FRAME) step();
        total++;
        if (frame_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bnd_ready_back got=%b want 1", frame_ready);
        end
        while (p < 1188) step();
        total++;
        if (led !== 8'h00 || col !== 4'b1101) begin
            bad++;
            $display("[TB] FAIL bnd_new_frame led=%h col=%b want 00/1101", led, col);
        end
    endtask

    // Reset at slot count 20 of column 2 with a frame pending.
    task automatic test_reset_midslot();
        frame_valid  = 1'b1;
        frame_data   = 32'hFFFF_FFFF;
        frame_bright = 4'd15;
        step();
        frame_valid = 1'b0;
        while (p < 1236) step();
        total++;
        if (col !== 4'b1011 || frame_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_pre col=%b ready=%b want 1011/0", col, frame_ready);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (led !== 8'hFF || col !== 4'hF || frame_ready !== 1'b1 || frame_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_async led=%h col=%b ready=%b done=%b want ff/1111/1/0", led, col, frame_ready, frame_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        while (p < FRAME + 12) begin
            step();
            total++;
            if (led !== 8'hFF || col !== exp_col) begin
                bad++;
                $display("[TB] FAIL rst_rescan p=%0d led=%h col=%b want ff/%b", p, led, col, exp_col);
            end
            total++;
            if (frame_ready !== 1'b1 || frame_done !== m_done) begin
                bad++;
                $display("[TB] FAIL rst_handshake p=%0d ready=%b done=%b want 1/%b", p, frame_ready, frame_done, m_done);
            end
            if (p == 4) begin
                total++;
                if (col !== 4'b1110) begin
                    bad++;
                    $display("[TB] FAIL rst_col0 col=%b want 1110", col);
                end
            end
        end
    endtask

    initial begin
        $display("[TB] led_scan_ctrl bench start");
        test_reset();
        test_bright15();
        test_bright0();
        test_back_to_back();
        test_boundary_accept();
        test_reset_midslot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter SLOT_CYCLES, default 3000, clock cycles per column slot, legal range 32..65535.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, clock cycles of leading blanking per slot, legal range 1..SLOT_CYCLES-16.
REQ-003 SHALL have port clk, input, 1 bit, sole clock; the block uses one clock.
REQ-004 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have port frame_data, input, 32 bits, pixel map; bit 8*c+r is row r of column c, 1 = lit.
REQ-006 SHALL have port frame_bright, input, 4 bits, frame brightness 0..15.
REQ-007 SHALL have port frame_valid, input, 1 bit, the producer offers frame_data/frame_bright.
REQ-008 SHALL have port frame_ready, output, 1 bit, the pending buffer is empty.
REQ-009 SHALL have port frame_done, output, 1 bit, one-cycle pulse at the end of each full 4-column scan.
REQ-010 SHALL have port led, output, 8 bits, row drive, active-low.
REQ-011 SHALL have port col, output, 4 bits, column select, active-low, at most one bit low.

Function
REQ-012 SHALL accept a frame on a cycle with frame_valid=1 and frame_ready=1, capturing frame_data and frame_bright into a pending buffer; frame_ready SHALL be low from the next cycle.
REQ-013 SHALL copy the pending buffer into the active buffer at the frame boundary (last cycle of the column-3 slot), then raise frame_ready on the next cycle.
REQ-014 SHALL keep the active buffer unchanged across boundaries when no frame is pending, redisplaying the last frame.
REQ-015 SHALL take the new frame into pending when an accept and a boundary coincide, and SHALL NOT promote that frame at that boundary.
REQ-016 SHALL implement the FSM states BLANK and DRIVE; slot counter 0..SLOT_CYCLES-1; BLANK while count < BLANK_CYCLES, else DRIVE; on count wrap, column index increments mod 4 and the state returns to BLANK.
REQ-017 SHALL, in BLANK, drive led=8'hFF and col=4'hF.
REQ-018 SHALL, in DRIVE for column c, drive col = ~(4'b0001<<c).
REQ-019 SHALL, in DRIVE, run a 4-bit PWM counter starting at 0 on entry to DRIVE and wrapping 15->0.
REQ-020 SHALL, in DRIVE, set led[r] = ~(active[8*c+r] & (pwm < active_bright)).
REQ-021 SHALL therefore keep a pixel dark at brightness 0 and lit 15 of every 16 DRIVE cycles at brightness 15.
REQ-022 SHALL register all outputs, with no combinational path from inputs to led/col.
REQ-023 SHALL assert frame_done exactly on the cycle following each frame boundary.

Reset
REQ-024 SHALL, on rst_n low and without waiting for clk, force led=8'hFF, col=4'hF, frame_ready=1, frame_done=0, active and pending buffers to 0, active_bright=0, state BLANK, column 0, counters 0.
REQ-025 SHALL drop all outputs to reset values at once on reset mid-slot or mid-handshake, discarding any pending frame.
REQ-026 SHALL start the first post-reset slot at column 0 in BLANK.

Structure
REQ-027 SHALL place the FSM state encoding (BLANK, DRIVE), LED_OFF=8'hFF and COL_OFF=4'hF in a shared package led_pkg.
REQ-028 SHALL contain one sub-module, led_pwm, holding the 4-bit PWM counter and compare and producing a lit-enable.

Verification (SLOT_CYCLES=32, BLANK_CYCLES=4)
REQ-029 SHALL cover: after reset, send frame 32'h0000_00FF with bright 15; at the next boundary, column 0 shows led=8'h00 on 15 of 16 DRIVE cycles, and columns 1-3 show led=8'hFF with col cycling 1101, 1011, 0111.
REQ-030 SHALL cover: bright 0 with all bits set; led=8'hFF at all times and col still scans.
REQ-031 SHALL cover: hold frame_valid continuously; exactly one accept per frame (every 128 cycles), frame_ready low between accepts, and frame_done pulsing every 128 cycles.
REQ-032 SHALL cover: an accept on the boundary cycle; that frame is displayed only after the following boundary.
REQ-033 SHALL cover: rst_n low at slot count 20 of column 2; led=8'hFF and col=4'hF in the same cycle, and after release a scan restarts at column 0 with dark pixels.
REQ-034 SHALL cover: a bench monitor that checks every cycle that col never has more than one zero bit, and that led=8'hFF whenever col=4'hF.
